// File: rtl/zx_io_pkg.sv
// Shared constants and types for the ZX ULA I/O port devices.
// FE bit layout, port-select decode and the OUT-cycle FSM states.
package zx_io_pkg;

  localparam int BORDER_LSB = 0;
  localparam int MIC_BIT    = 3;
  localparam int EAR_BIT    = 4;

  // The ULA answers any even port address.
  localparam logic PORT_A0 = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } wr_state_e;

  // rd and wr together is a bus conflict, never a write.
  function automatic logic port_hit(
    input logic ce,
    input logic rd,
    input logic wr,
    input logic a0
  );
    return ce & wr & ~rd & (a0 == PORT_A0);
  endfunction

endpackage

// File: rtl/io_device_out_if.sv
// CPU bus and border-event handshake bundle for io_device_out.
// master: CPU/decoder + video consumer side; slave: the port device.
interface io_device_out_if;

  logic        ce;
  logic        rd;
  logic        wr;
  logic [15:0] ad;
  logic [7:0]  data_bus;
  logic [2:0]  border;
  logic        mic;
  logic        ear;
  logic        evt_valid;
  logic [2:0]  evt_border;
  logic        evt_ready;
  logic        evt_overflow;
  logic [15:0] tone_period;

  modport master (
    output ce, rd, wr, ad, data_bus,
    output evt_ready,
    input  border, mic, ear,
    input  evt_valid, evt_border,
    input  evt_overflow, tone_period
  );

  modport slave (
    input  ce, rd, wr, ad, data_bus,
    input  evt_ready,
    output border, mic, ear,
    output evt_valid, evt_border,
    output evt_overflow, tone_period
  );

endinterface

// File: rtl/io_evt_fifo.sv
// Synchronous FIFO for border-change events with sticky overflow.
// Ports: push_i/data_i in, pop_i/head_o out, full_o, empty_o, overflow_o.
module io_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));

  // A pop in the same cycle frees the slot a full push needs.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign head_o     = empty_o ? '0 : mem_q[rd_ptr_q];
  assign overflow_o = ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (push_i && !do_push) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_device_out.sv
// ULA output port (0xFE): border/MIC/EAR latch plus border-event FIFO.
// Ports: clk, reset, bus (io_device_out_if.slave). Option: IO_OUT_TONE_EN.
module io_device_out
  import zx_io_pkg::*;
#(
  parameter int WR_SETTLE  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  io_device_out_if.slave bus
);

  wr_state_e  state_q;
  wr_state_e  state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       hit;
  logic       capture;

  logic [2:0] border_q;
  logic       mic_q;
  logic       ear_q;
  logic [2:0] new_border;
  logic       evt_push;
  logic       evt_full_unused;
  logic       evt_empty;
  logic       unused_bits;

  assign hit = port_hit(bus.ce, bus.rd, bus.wr, bus.ad[0]);

  assign unused_bits = ^{bus.ad[15:1], bus.data_bus[7:5]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = SETTLE;
          cnt_d   = 4'(WR_SETTLE - 1);
        end
      end
      SETTLE: begin
        if (!hit) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (!hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign new_border = bus.data_bus[BORDER_LSB +: 3];
  assign evt_push   = capture & (new_border != border_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      border_q <= '0;
      mic_q    <= 1'b0;
      ear_q    <= 1'b0;
    end else if (capture) begin
      border_q <= new_border;
      mic_q    <= bus.data_bus[MIC_BIT];
      ear_q    <= bus.data_bus[EAR_BIT];
    end
  end

  assign bus.border = border_q;
  assign bus.mic    = mic_q;
  assign bus.ear    = ear_q;

  io_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (3)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (evt_push),
    .data_i     (new_border),
    .pop_i      (bus.evt_ready),
    .head_o     (bus.evt_border),
    .full_o     (evt_full_unused),
    .empty_o    (evt_empty),
    .overflow_o (bus.evt_overflow)
  );

  assign bus.evt_valid = ~evt_empty;

`ifdef IO_OUT_TONE_EN
  logic [15:0] tone_cnt_q;
  logic [15:0] tone_q;

  // Cycles between EAR edges; the counter saturates on silence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tone_cnt_q <= '0;
      tone_q     <= '0;
    end else if (capture && bus.data_bus[EAR_BIT] != ear_q) begin
      tone_q     <= tone_cnt_q;
      tone_cnt_q <= '0;
    end else if (tone_cnt_q != 16'hFFFF) begin
      tone_cnt_q <= tone_cnt_q + 1'b1;
    end
  end

  assign bus.tone_period = tone_q;
`else
  assign bus.tone_period = '0;
`endif

endmodule

// File: tb/tb_io_device_out.sv
// Directed bench for io_device_out (WR_SETTLE=2, FIFO_DEPTH=4).
// Build with IO_OUT_TONE_EN defined to exercise the tone period.
module tb_io_device_out;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  io_device_out_if bus();

  io_device_out #(
    .WR_SETTLE  (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    bus.ce       = 1'b0;
    bus.wr       = 1'b0;
    bus.rd       = 1'b0;
    bus.ad       = 16'hFFFF;
    bus.data_bus = 8'h00;
  endtask

  task automatic set_hit(input logic [7:0] d);
    bus.ce       = 1'b1;
    bus.wr       = 1'b1;
    bus.rd       = 1'b0;
    bus.ad       = 16'hFFFE;
    bus.data_bus = d;
  endtask

  // Capture lands on the third edge; pop_cap pops on that edge.
  task automatic wr_byte(
    input logic [7:0] d,
    input bit         pop_cap
  );
    set_hit(d);
    tick;
    tick;
    if (pop_cap) bus.evt_ready = 1'b1;
    tick;
    bus.evt_ready = 1'b0;
    tick;
    idle_bus;
    tick;
  endtask

  task automatic pop1;
    bus.evt_ready = 1'b1;
    tick;
    bus.evt_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".border"}, 16'(bus.border), 16'h0);
    chk({tag, ".mic"}, 16'(bus.mic), 16'h0);
    chk({tag, ".ear"}, 16'(bus.ear), 16'h0);
    chk({tag, ".valid"}, 16'(bus.evt_valid), 16'h0);
    chk({tag, ".evtb"}, 16'(bus.evt_border), 16'h0);
    chk({tag, ".ovf"}, 16'(bus.evt_overflow), 16'h0);
    chk({tag, ".tone"}, bus.tone_period, 16'h0);
  endtask

  logic [2:0]  exp_q [4];
  logic [15:0] tp;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.evt_ready = 1'b0;
    idle_bus;
    tick;
    tick;
    chk_all_zero("rst");
    reset = 1'b0;
    tick;

    // first write: 0x15, capture on the third edge
    set_hit(8'h15);
    tick;
    chk("t1.e0", 16'(bus.border), 16'h0);
    tick;
    chk("t1.e1", 16'(bus.border), 16'h0);
    chk("t1.e1v", 16'(bus.evt_valid), 16'h0);
    tick;
    chk("t1.border", 16'(bus.border), 16'h5);
    chk("t1.mic", 16'(bus.mic), 16'h0);
    chk("t1.ear", 16'(bus.ear), 16'h1);
    chk("t1.valid", 16'(bus.evt_valid), 16'h1);
    chk("t1.evtb", 16'(bus.evt_border), 16'h5);
    tick;
    tick;
    idle_bus;
    tick;
    pop1;
    chk("t1.one", 16'(bus.evt_valid), 16'h0);

    // same border: no event
    wr_byte(8'h05, 1'b0);
    wr_byte(8'h05, 1'b0);
    chk("t2.valid", 16'(bus.evt_valid), 16'h0);
    chk("t2.ear", 16'(bus.ear), 16'h0);

    // rd&wr, odd port, no ce: all ignored
    set_hit(8'h02);
    bus.rd = 1'b1;
    repeat (4) tick;
    set_hit(8'h02);
    bus.ad = 16'h00FF;
    repeat (4) tick;
    set_hit(8'h02);
    bus.ce = 1'b0;
    repeat (4) tick;
    idle_bus;
    tick;
    chk("t2.rdwr", 16'(bus.border), 16'h5);
    chk("t2.nov", 16'(bus.evt_valid), 16'h0);

    // one-cycle strobe aborts settle
    set_hit(8'h03);
    tick;
    idle_bus;
    repeat (3) tick;
    chk("t3.short", 16'(bus.border), 16'h5);
    chk("t3.nov", 16'(bus.evt_valid), 16'h0);

    // back in IDLE: full latency again, no recapture in HOLD
    set_hit(8'h01);
    tick;
    tick;
    chk("t3.lat", 16'(bus.border), 16'h5);
    tick;
    chk("t3.cap", 16'(bus.border), 16'h1);
    bus.data_bus = 8'h07;
    tick;
    tick;
    chk("t3.hold", 16'(bus.border), 16'h1);
    idle_bus;
    tick;
    chk("t3.evtb", 16'(bus.evt_border), 16'h1);
    pop1;
    chk("t3.empty", 16'(bus.evt_valid), 16'h0);

    // overflow: five changes into depth 4
    wr_byte(8'h02, 1'b0);
    wr_byte(8'h03, 1'b0);
    wr_byte(8'h04, 1'b0);
    wr_byte(8'h06, 1'b0);
    chk("t4.noovf", 16'(bus.evt_overflow), 16'h0);
    wr_byte(8'h07, 1'b0);
    chk("t4.border", 16'(bus.border), 16'h7);
    chk("t4.ovf", 16'(bus.evt_overflow), 16'h1);
    chk("t4.head", 16'(bus.evt_border), 16'h2);
    bus.evt_ready = 1'b1;
    tick;
    chk("t4.d1", 16'(bus.evt_border), 16'h3);
    tick;
    chk("t4.d2", 16'(bus.evt_border), 16'h4);
    tick;
    chk("t4.d3", 16'(bus.evt_border), 16'h6);
    chk("t4.v3", 16'(bus.evt_valid), 16'h1);
    tick;
    chk("t4.v4", 16'(bus.evt_valid), 16'h0);
    tick;
    chk("t4.v5", 16'(bus.evt_valid), 16'h0);
    bus.evt_ready = 1'b0;
    chk("t4.sticky", 16'(bus.evt_overflow), 16'h1);

    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    chk_all_zero("rst2");

    // full FIFO, push and pop on the same edge
    wr_byte(8'h01, 1'b0);
    wr_byte(8'h02, 1'b0);
    wr_byte(8'h03, 1'b0);
    wr_byte(8'h04, 1'b0);
    chk("t5.head", 16'(bus.evt_border), 16'h1);
    wr_byte(8'h05, 1'b1);
    chk("t5.border", 16'(bus.border), 16'h5);
    chk("t5.noovf", 16'(bus.evt_overflow), 16'h0);
    exp_q[0] = 3'd2;
    exp_q[1] = 3'd3;
    exp_q[2] = 3'd4;
    exp_q[3] = 3'd5;
    for (int i = 0; i < 4; i++) begin
      chk("t5.drain", 16'(bus.evt_border),
          16'(exp_q[i]));
      pop1;
    end
    chk("t5.empty", 16'(bus.evt_valid), 16'h0);
    pop1;
    chk("t5.popempty", 16'(bus.evt_valid), 16'h0);

    // async reset mid-SETTLE, then a full settle again
    wr_byte(8'h1B, 1'b0);
    chk("t6.mic", 16'(bus.mic), 16'h1);
    chk("t6.ear", 16'(bus.ear), 16'h1);
    chk("t6.valid", 16'(bus.evt_valid), 16'h1);
    set_hit(8'h16);
    tick;
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("t6.async");
    #2;
    reset = 1'b0;
    tick;
    tick;
    chk("t6.resettle", 16'(bus.border), 16'h0);
    tick;
    chk("t6.cap", 16'(bus.border), 16'h6);
    idle_bus;
    tick;
    pop1;

    // EAR toggles every 100 cycles
    for (int k = 0; k < 4; k++) begin
      wr_byte((k % 2 == 0) ? 8'h06 : 8'h16, 1'b0);
      repeat (95) tick;
    end
    tp = bus.tone_period;
`ifdef IO_OUT_TONE_EN
    n_vec++;
    assert (tp >= 16'd99 && tp <= 16'd101) else begin
      n_err++;
      $error("FAIL tone observed=%0d expected=100+-1", tp);
    end
`else
    chk("tone.off", tp, 16'h0);
`endif
    chk("tone.ev", 16'(bus.evt_valid), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_device_out.md
Name: io_device_out

Overview:
- CPU-write responder for the ULA output port (0xFE); the output-side counterpart of the keyboard input port reader on the same Z80 I/O bus.
- Captures exactly one byte per CPU OUT cycle and drives the border colour, MIC and EAR/beeper levels.
- Queues border-colour changes in a small FIFO with a valid/ready handshake so the video side can consume them.
- Sits beside the input port device, enabled by the decoder's io_cs strobe, all in the clk_spectrum domain.

Parameters:
- WR_SETTLE, 2, cycles the strobe must stay asserted before data_bus is sampled (1..15).
- FIFO_DEPTH, 4, border-event FIFO entries (power of two, 2..16).

Ports:
- clk  input  1  spectrum clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- ce  input  1  port chip-select from the decoder (io_cs line).
- rd  input  1  CPU read strobe, active-high. Ignored except that rd&wr together is treated as no write.
- wr  input  1  CPU write strobe, active-high.
- ad  input  16  address bus. Only ad[0]==0 is accepted.
- data_bus  input  8  CPU data bus, sampled at capture.
- border  output  3  current border colour.
- mic  output  1  MIC level.
- ear  output  1  EAR/beeper level.
- evt_valid  output  1  FIFO not empty.
- evt_border  output  3  head-of-FIFO border value.
- evt_ready  input  1  consumer pops the head when evt_valid&evt_ready.
- evt_overflow  output  1  sticky; an event was dropped.
- tone_period  output  16  see Optional Feature.

Behaviour:
- Strobe: hit = ce & wr & ~rd & ~ad[0].
- FSM states: IDLE, SETTLE, HOLD. Reset state is IDLE.
  - IDLE -> SETTLE when hit. The settle counter is loaded with WR_SETTLE-1.
  - SETTLE: decrement each cycle while hit.
    - If hit drops: go to IDLE, no capture.
    - If counter==0 and hit: capture data_bus and go to HOLD.
  - HOLD: stay while hit; go to IDLE when hit drops. No further capture inside one strobe.
- With WR_SETTLE=1, capture occurs on the 1st cycle of the SETTLE state, i.e. 2 cycles after hit rises.
- Capture loads border<=d[2:0], mic<=d[3], ear<=d[4]. These outputs update the cycle after capture. d[7:5] is ignored.
- Border event: pushed on capture only if the new d[2:0] differs from the current border.
- FIFO:
  - evt_valid=1 whenever the FIFO is non-empty; evt_border shows the head.
  - Pop occurs when evt_valid&evt_ready.
  - Push while full with a pop in the same cycle: both happen, no drop.
  - Push while full without a pop: the event is dropped and evt_overflow<=1 until reset.
  - Pop while empty: ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH. Use an occupancy count of $clog2(FIFO_DEPTH)+1 bits.
- Reset values (asynchronous, while reset high): border=0, mic=0, ear=0, evt_valid=0, evt_border=0, evt_overflow=0, tone_period=0. FIFO is emptied and the FSM returns to IDLE.
- Reset mid-strobe: the capture is discarded. After reset releases with hit still high, the FSM goes IDLE->SETTLE and a full settle runs again.

Optional Feature:
- Macro: IO_OUT_TONE_EN.
- Defined:
  - A 16-bit counter increments every clk and saturates at 0xFFFF.
  - On each capture that changes ear, tone_period<=counter and the counter clears to 0.
  - tone_period holds between toggles.
- Undefined: tone_period tied to 0 and no counter is synthesised.

Decomposition:
- Shared package zx_io_pkg holds:
  - FE bit positions: BORDER_LSB=0, MIC_BIT=3, EAR_BIT=4.
  - Port-select constant (ad[0]==0).
  - FSM state typedef {IDLE, SETTLE, HOLD}.
- Sub-module io_evt_fifo: parameterised synchronous FIFO with push, pop, full, empty and overflow-sticky logic, instantiated once.

Test Plan:
- Reset, then WR_SETTLE=2, hit held 5 cycles with data 0x15: capture 3 cycles after hit rises. Then border=5, mic=0, ear=1, evt_valid=1, evt_border=5; only one event.
- Write 0x05 twice with the border already 5: no new event, FIFO count unchanged.
- hit asserted for 1 cycle only with WR_SETTLE=2: outputs unchanged, FSM back in IDLE.
- 5 distinct border writes with evt_ready=0 and depth 4: 4 events held, evt_overflow=1. Then drain with evt_ready=1: events pop in FIFO order and evt_valid drops.
- FIFO full, push and pop in the same cycle: no overflow, count stays 4, head advances.
- IO_OUT_TONE_EN defined: EAR toggled every 100 cycles gives tone_period=100 ±1. With the macro undefined, tone_period stays 0. Assert reset mid-SETTLE: all outputs return to 0 asynchronously.
